// File: rtl/param_main_memory.sv
// param_main_memory: byte-addressed main-memory model with one outstanding
// request, programmable access latency, per-byte write strobes, range
// checking and an approximate-read mode that truncates the low bits of every
// returned byte. Each response carries the addressed word, the enclosing line
// and the line tag for cache refill.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request to capture
// BUSY  | request captured, latency down-counter running to terminal count
// RESP  | response registers loaded, held until resp_ready is seen
module param_main_memory #(
  parameter int ADDR_W     = 32,
  parameter int MEM_BYTES  = 8192,
  parameter int LINE_BYTES = 32,
  parameter int TAG_LSB    = 7,
  parameter int LATENCY    = 4,
  parameter int APPROX_LSB = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_wstrb,
  input  logic                      req_approx,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_wr,
  output logic                      resp_err,
  output logic [31:0]               resp_word,
  output logic [LINE_BYTES*8-1:0]   resp_line,
  output logic [ADDR_W-TAG_LSB-1:0] resp_tag
);

  localparam int MEM_AW  = $clog2(MEM_BYTES);
  localparam int LOFF_W  = $clog2(LINE_BYTES);
  localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [7:0] APPROX_MASK = 8'(8'hFF << APPROX_LSB);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Power-up image of the array: byte i holds i mod 10. Reset never touches it.
  function automatic logic [MEM_BYTES-1:0][7:0] mem_init();
    logic [MEM_BYTES-1:0][7:0] m;
    for (int i = 0; i < MEM_BYTES; i++) begin
      m[i] = 8'(i % 10);
    end
    return m;
  endfunction

  logic [MEM_BYTES-1:0][7:0] mem = mem_init();

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-3:0]   cap_waddr;
  logic                cap_wr;
  logic [31:0]         cap_wdata;
  logic [3:0]          cap_wstrb;
  logic                cap_approx;

  logic [ADDR_W:0]     word_end;
  logic                addr_err;
  logic                do_access;
  logic                mem_we;
  logic [MEM_AW-1:0]   wb;
  logic [MEM_AW-1:0]   lb;
  logic [7:0]          line_b [LINE_BYTES];
  logic [31:0]         word_c;
  logic [LINE_BYTES*8-1:0] line_c;

  // The two address LSBs are don't-care: every access is word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign word_end  = {1'b0, cap_waddr, 2'b11};
  assign addr_err  = (word_end >= (ADDR_W+1)'(MEM_BYTES));
  assign do_access = (state == BUSY) && (cnt == '0);
  assign mem_we    = do_access && cap_wr && !addr_err;
  assign wb        = {cap_waddr[MEM_AW-3:0], 2'b00};
  assign lb        = wb & ~MEM_AW'(LINE_BYTES - 1);

  // Build the line as it will look after this access: strobed write bytes
  // are merged in so a write response returns post-write contents, and
  // approximate reads have their low bits masked.
  always_comb begin
    logic [MEM_AW-1:0] a;
    logic [7:0]        b;
    line_c = '0;
    word_c = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      a = lb + MEM_AW'(k);
      b = mem[a];
      if (cap_wr && (a[MEM_AW-1:2] == wb[MEM_AW-1:2]) && cap_wstrb[~a[1:0]]) begin
        b = cap_wdata[{~a[1:0], 3'b000} +: 8];
      end
      if (!cap_wr && cap_approx) begin
        b = b & APPROX_MASK;
      end
      line_b[k] = b;
      line_c[(LINE_BYTES-1-k)*8 +: 8] = b;
    end
    for (int j = 0; j < 4; j++) begin
      word_c[31-8*j -: 8] = line_b[int'(wb[LOFF_W-1:0]) + j];
    end
  end

  // Array write on the completion edge; async reset forces IDLE, so an
  // aborted write never reaches the array.
  always_ff @(posedge clk) begin
    for (int j = 0; j < 4; j++) begin
      if (mem_we && cap_wstrb[3-j]) begin
        mem[wb + MEM_AW'(j)] <= cap_wdata[31-8*j -: 8];
      end
    end
  end

  // Request/latency/response sequencing with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      cap_waddr  <= '0;
      cap_wr     <= 1'b0;
      cap_wdata  <= '0;
      cap_wstrb  <= '0;
      cap_approx <= 1'b0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_err   <= 1'b0;
      resp_word  <= '0;
      resp_line  <= '0;
      resp_tag   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap_waddr  <= req_addr[ADDR_W-1:2];
            cap_wr     <= req_wr;
            cap_wdata  <= req_wdata;
            cap_wstrb  <= req_wstrb;
            cap_approx <= req_approx;
            cnt        <= CNT_W'(LATENCY - 1);
            req_ready  <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            resp_valid <= 1'b1;
            resp_wr    <= cap_wr;
            resp_err   <= addr_err;
            resp_word  <= addr_err ? '0 : word_c;
            resp_line  <= addr_err ? '0 : line_c;
            resp_tag   <= cap_waddr[ADDR_W-3:TAG_LSB-2];
            state      <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_main_memory.sv
// tb_param_main_memory: directed plan steps followed by random traffic, all
// checked against a byte-array reference model of the memory.
module tb_param_main_memory;

  localparam int ADDR_W     = 32;
  localparam int MEM_BYTES  = 8192;
  localparam int LINE_BYTES = 32;
  localparam int TAG_LSB    = 7;
  localparam int LATENCY    = 4;
  localparam int APPROX_LSB = 2;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic                      req_wr = 1'b0;
  logic [ADDR_W-1:0]         req_addr = '0;
  logic [31:0]               req_wdata = '0;
  logic [3:0]                req_wstrb = '0;
  logic                      req_approx = 1'b0;
  logic                      resp_valid;
  logic                      resp_ready = 1'b0;
  logic                      resp_wr;
  logic                      resp_err;
  logic [31:0]               resp_word;
  logic [LINE_BYTES*8-1:0]   resp_line;
  logic [ADDR_W-TAG_LSB-1:0] resp_tag;

  param_main_memory #(
    .ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES), .LINE_BYTES(LINE_BYTES),
    .TAG_LSB(TAG_LSB), .LATENCY(LATENCY), .APPROX_LSB(APPROX_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_approx(req_approx),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_wr(resp_wr),
    .resp_err(resp_err), .resp_word(resp_word), .resp_line(resp_line),
    .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]              mm [MEM_BYTES];
  logic [31:0]             e_word;
  logic [LINE_BYTES*8-1:0] e_line;
  logic [ADDR_W-TAG_LSB-1:0] e_tag;
  logic                    e_err;
  logic [31:0]             g_word;
  logic [LINE_BYTES*8-1:0] g_line;
  logic [ADDR_W-TAG_LSB-1:0] g_tag;
  logic                    g_err;
  logic                    g_wr;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] trunc(input logic [7:0] b);
    return 8'(int'(b) - (int'(b) % (1 << APPROX_LSB)));
  endfunction

  // Reference model: apply the access to the byte array and form the response.
  task automatic predict(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic ap);
    longint base;
    int     bi, lb;
    logic [7:0] b;
    base   = longint'(addr) - (longint'(addr) % 4);
    e_err  = (base + 3) >= MEM_BYTES;
    e_tag  = addr[ADDR_W-1:TAG_LSB];
    e_word = '0;
    e_line = '0;
    if (!e_err) begin
      bi = int'(base);
      if (wr) begin
        for (int j = 0; j < 4; j++)
          if (strb[3-j]) mm[bi+j] = wdata[31-8*j -: 8];
      end
      lb = bi - (bi % LINE_BYTES);
      for (int k = 0; k < LINE_BYTES; k++) begin
        b = mm[lb+k];
        if (!wr && ap) b = trunc(b);
        e_line[(LINE_BYTES-1-k)*8 +: 8] = b;
      end
      for (int j = 0; j < 4; j++) begin
        b = mm[bi+j];
        if (!wr && ap) b = trunc(b);
        e_word[31-8*j -: 8] = b;
      end
    end
  endtask

  task automatic run_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic ap, input int hold);
    int n;
    @(negedge clk);
    chk("idle_ready", 256'(req_ready), 256'(1));
    req_valid = 1'b1; req_wr = wr; req_addr = addr;
    req_wdata = wdata; req_wstrb = strb; req_approx = ap;
    @(negedge clk);
    req_valid = 1'b0;
    req_wr = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_wstrb = 4'($urandom); req_approx = 1'($urandom);
    chk("busy_ready", 256'(req_ready), 256'(0));
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 256'(n), 256'(LATENCY));
    predict(wr, addr, wdata, strb, ap);
    g_word = resp_word; g_line = resp_line; g_tag = resp_tag;
    g_err = resp_err; g_wr = resp_wr;
    chk("resp_word", 256'(g_word), 256'(e_word));
    chk("resp_line", 256'(g_line), 256'(e_line));
    chk("resp_tag", 256'(g_tag), 256'(e_tag));
    chk("resp_err", 256'(g_err), 256'(e_err));
    chk("resp_wr", 256'(g_wr), 256'(wr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 256'(resp_valid), 256'(1));
      chk("hold_ready", 256'(req_ready), 256'(0));
      chk("hold_word", 256'(resp_word), 256'(e_word));
      chk("hold_line", 256'(resp_line), 256'(e_line));
      chk("hold_tag", 256'(resp_tag), 256'(e_tag));
      chk("hold_err", 256'(resp_err), 256'(e_err));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("release_valid", 256'(resp_valid), 256'(0));
    chk("release_ready", 256'(req_ready), 256'(1));
  endtask

  initial begin
    int seen;
    logic [31:0] ra;
    for (int i = 0; i < MEM_BYTES; i++) mm[i] = 8'(i % 10);

    // reset state
    @(negedge clk);
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_resp_valid", 256'(resp_valid), 256'(0));
    chk("rst_resp_wr", 256'(resp_wr), 256'(0));
    chk("rst_resp_err", 256'(resp_err), 256'(0));
    chk("rst_resp_word", 256'(resp_word), 256'(0));
    chk("rst_resp_line", 256'(resp_line), 256'(0));
    chk("rst_resp_tag", 256'(resp_tag), 256'(0));
    rst_n = 1'b1;

    // plain read
    run_req(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 0);
    chk("plan_rd_word", 256'(g_word), 256'(32'h06070809));
    chk("plan_rd_top", 256'(g_line[255:248]), 256'(8'h02));
    chk("plan_rd_bot", 256'(g_line[7:0]), 256'(8'h03));
    chk("plan_rd_tag", 256'(g_tag), 256'(0));

    // strobed write then read back
    run_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b0110, 1'b0, 0);
    chk("plan_wr_word", 256'(g_word), 256'(32'h06ADBE09));
    chk("plan_wr_flag", 256'(g_wr), 256'(1));
    run_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1);
    chk("plan_wr_rdback", 256'(g_word), 256'(32'h06ADBE09));

    // approximate read leaves storage intact
    run_req(1'b0, 32'h24, 32'h0, 4'h0, 1'b1, 0);
    chk("plan_apx_word", 256'(g_word), 256'(32'h04040808));
    run_req(1'b0, 32'h26, 32'h0, 4'h0, 1'b0, 0);
    chk("plan_apx_after", 256'(g_word), 256'(32'h06070809));

    // range boundaries
    run_req(1'b0, 32'h2000, 32'h0, 4'h0, 1'b0, 0);
    chk("plan_oor_err", 256'(g_err), 256'(1));
    chk("plan_oor_tag", 256'(g_tag), 256'(32'h40));
    run_req(1'b1, 32'h2000, 32'h11223344, 4'hF, 1'b0, 0);
    run_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 0);
    chk("plan_oor_nowr", 256'(g_word), 256'(32'h00010203));
    run_req(1'b0, 32'h1FFF, 32'h0, 4'h0, 1'b0, 0);
    chk("plan_last_ok", 256'(g_err), 256'(0));
    run_req(1'b1, 32'h1FFC, 32'hCAFEF00D, 4'b1001, 1'b0, 0);

    // backpressure
    run_req(1'b0, 32'h3C, 32'h0, 4'h0, 1'b1, 3);

    // reset in the middle of a write
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0;
    req_wdata = 32'hAABBCCDD; req_wstrb = 4'hF; req_approx = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("midrst_ready", 256'(req_ready), 256'(1));
    chk("midrst_word", 256'(resp_word), 256'(0));
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("midrst_no_resp", 256'(seen), 256'(0));
    run_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 0);
    chk("midrst_rdback", 256'(g_word), 256'(32'h00010203));

    // random traffic
    for (int t = 0; t < 50; t++) begin
      if ($urandom_range(0, 7) == 0) ra = $urandom;
      else ra = 32'($urandom_range(0, MEM_BYTES - 1));
      run_req(1'($urandom), ra, $urandom, 4'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
